// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks the columns active-low, debounces one key
// and presents its column/row code with an active-low valid strobe.
//
// state    | meaning
// SCAN     | stepping through columns, looking for any low row
// DEBOUNCE | column frozen, counting consecutive ticks with the candidate row low
// HOLD     | key accepted, codes valid, waiting for the row to go high
// RELEASE  | counting consecutive ticks with the held row high
module keypad_scanner #(
  parameter int SCAN_DIV   = 27000,
  parameter int DEBOUNCE_N = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] fila_i,
  output logic [3:0] columna_o,
  output logic [1:0] dato_codc_o,
  output logic [1:0] dato_codf_o,
  output logic       dato_listo_o,
  output logic       tecla_pulso_o
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_N + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_N);
  localparam logic [DW-1:0] DB_ONE    = DW'(1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;

  state_t        state;
  logic [3:0]    sync_1, fs;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [DW-1:0] db_cnt, db_next;
  logic          db_done, db_first_done;
  logic [1:0]    col_idx, cand_col, cand_row, row_code;
  logic          hit, cand_low;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_1 <= 4'b1111;
      fs     <= 4'b1111;
    end else begin
      sync_1 <= fila_i;
      fs     <= sync_1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (!rst)      tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TW'(1);
  end

  // Lowest-numbered low row wins when several rows are pulled down.
  always_comb begin
    row_code = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!fs[i]) row_code = 2'(i);
    end
  end

  assign hit           = ~&fs;
  assign cand_low      = ~fs[cand_row];
  assign db_next       = db_cnt + DB_ONE;
  assign db_done       = (db_next == DB_LAST);
  assign db_first_done = (DB_ONE == DB_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= SCAN;
      col_idx       <= 2'd0;
      columna_o     <= 4'b1110;
      cand_col      <= 2'd0;
      cand_row      <= 2'd0;
      db_cnt        <= '0;
      dato_codc_o   <= 2'd0;
      dato_codf_o   <= 2'd0;
      dato_listo_o  <= 1'b1;
      tecla_pulso_o <= 1'b0;
    end else begin
      tecla_pulso_o <= 1'b0;
      if (tick) begin
        unique case (state)
          SCAN: begin
            if (hit) begin
              cand_col <= col_idx;
              cand_row <= row_code;
              if (db_first_done) begin
                state         <= HOLD;
                db_cnt        <= '0;
                dato_codc_o   <= col_idx;
                dato_codf_o   <= row_code;
                dato_listo_o  <= 1'b0;
                tecla_pulso_o <= 1'b1;
              end else begin
                state  <= DEBOUNCE;
                db_cnt <= DB_ONE;
              end
            end else begin
              col_idx   <= col_idx + 2'd1;
              columna_o <= {columna_o[2:0], columna_o[3]};
            end
          end
          DEBOUNCE: begin
            if (hit && row_code == cand_row) begin
              if (db_done) begin
                state         <= HOLD;
                db_cnt        <= '0;
                dato_codc_o   <= cand_col;
                dato_codf_o   <= cand_row;
                dato_listo_o  <= 1'b0;
                tecla_pulso_o <= 1'b1;
              end else begin
                db_cnt <= db_next;
              end
            end else begin
              state     <= SCAN;
              db_cnt    <= '0;
              col_idx   <= col_idx + 2'd1;
              columna_o <= {columna_o[2:0], columna_o[3]};
            end
          end
          HOLD: begin
            if (!cand_low) begin
              if (db_first_done) begin
                state        <= SCAN;
                db_cnt       <= '0;
                dato_listo_o <= 1'b1;
                col_idx      <= col_idx + 2'd1;
                columna_o    <= {columna_o[2:0], columna_o[3]};
              end else begin
                state  <= RELEASE;
                db_cnt <= DB_ONE;
              end
            end
          end
          RELEASE: begin
            if (!cand_low) begin
              if (db_done) begin
                state        <= SCAN;
                db_cnt       <= '0;
                dato_listo_o <= 1'b1;
                col_idx      <= col_idx + 2'd1;
                columna_o    <= {columna_o[2:0], columna_o[3]};
              end else begin
                db_cnt <= db_next;
              end
            end else begin
              state  <= HOLD;
              db_cnt <= '0;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule
